// File: rtl/ibex_clic_arbiter.sv
// CLIC-style interrupt arbiter: keeps per-source configuration and pending
// state, picks the highest-level enabled pending source above threshold and
// presents it one-hot to the core, retiring edge pending bits on acknowledge.
module ibex_clic_arbiter #(
  parameter int NumInterrupts = 64,
  parameter int LevelW        = 8,
  parameter int IdW           = $clog2(NumInterrupts)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumInterrupts-1:0] irq_src_i,
  input  logic                     cfg_we_i,
  input  logic [IdW-1:0]           cfg_id_i,
  input  logic                     cfg_ie_i,
  input  logic                     cfg_edge_i,
  input  logic [LevelW-1:0]        cfg_level_i,
  input  logic                     cfg_shv_i,
  input  logic [1:0]               cfg_priv_i,
  input  logic [LevelW-1:0]        irq_thresh_i,
  input  logic [IdW-1:0]           core_irq_id_i,
  input  logic                     core_irq_ack_i,
  output logic [NumInterrupts-1:0] irq_o,
  output logic [LevelW-1:0]        irq_level_o,
  output logic                     irq_shv_o,
  output logic [1:0]               irq_priv_o,
  output logic                     ack_mismatch_o
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    BLANK
  } state_e;

  state_e state_q, state_d;

  logic [NumInterrupts-1:0] ie_q, edge_q, shv_q, pend_q, prev_src_q;
  logic [LevelW-1:0]        level_q [NumInterrupts];
  logic [1:0]               priv_q  [NumInterrupts];

  logic [NumInterrupts-1:0] cfg_sel, ack_sel, cfg_clr, rise, pend_d, eff_pend, cand;

  logic                     found;
  logic [NumInterrupts-1:0] win_oh;
  logic [IdW-1:0]           win_id;
  logic [LevelW-1:0]        win_level;
  logic                     win_shv;
  logic [1:0]               win_priv;

  logic [NumInterrupts-1:0] irq_q, irq_d;
  logic [LevelW-1:0]        level_out_q, level_out_d;
  logic                     shv_out_q, shv_out_d;
  logic [1:0]               priv_out_q, priv_out_d;
  logic [IdW-1:0]           sel_id_q, sel_id_d;
  logic                     mismatch_q, mismatch_d;

  // Decode config-write and acknowledge indices; out-of-range ids match nothing
  always_comb begin
    cfg_sel = '0;
    ack_sel = '0;
    for (int i = 0; i < NumInterrupts; i++) begin
      cfg_sel[i] = cfg_we_i && (cfg_id_i == IdW'(i));
      ack_sel[i] = core_irq_ack_i && (core_irq_id_i == IdW'(i));
    end
  end

  // Edge pending update: a new rising edge beats an ack clear, while a config
  // write that leaves edge mode or disables the source always clears it
  always_comb begin
    rise     = irq_src_i & ~prev_src_q & edge_q;
    cfg_clr  = cfg_sel & ((edge_q & {NumInterrupts{~cfg_edge_i}}) | {NumInterrupts{~cfg_ie_i}});
    pend_d   = ((pend_q & ~ack_sel) | rise) & ~cfg_clr;
    eff_pend = (edge_q & pend_q) | (~edge_q & irq_src_i);
  end

  // Arbitration: highest level wins, ascending scan with >= makes higher id win ties
  always_comb begin
    found     = 1'b0;
    win_oh    = '0;
    win_id    = '0;
    win_level = '0;
    win_shv   = 1'b0;
    win_priv  = '0;
    cand      = '0;
    for (int i = 0; i < NumInterrupts; i++) begin
      cand[i] = eff_pend[i] && ie_q[i] && (level_q[i] > irq_thresh_i);
      if (cand[i] && (!found || (level_q[i] >= win_level))) begin
        found     = 1'b1;
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = IdW'(i);
        win_level = level_q[i];
        win_shv   = shv_q[i];
        win_priv  = priv_q[i];
      end
    end
  end

  // Next-state and next-output logic: an ack forces one blank cycle, otherwise
  // the fresh arbitration result is presented
  always_comb begin
    state_d     = state_q;
    irq_d       = '0;
    level_out_d = '0;
    shv_out_d   = 1'b0;
    priv_out_d  = '0;
    sel_id_d    = '0;
    mismatch_d  = 1'b0;
    if (core_irq_ack_i) begin
      state_d    = BLANK;
      mismatch_d = (state_q != PRESENT) || (core_irq_id_i != sel_id_q);
    end else if (found) begin
      state_d     = PRESENT;
      irq_d       = win_oh;
      level_out_d = win_level;
      shv_out_d   = win_shv;
      priv_out_d  = win_priv;
      sel_id_d    = win_id;
    end else begin
      state_d = IDLE;
    end
  end

  // Configuration, pending, edge history, FSM state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q        <= '0;
      edge_q      <= '0;
      shv_q       <= '0;
      pend_q      <= '0;
      prev_src_q  <= '0;
      for (int i = 0; i < NumInterrupts; i++) begin
        level_q[i] <= '0;
        priv_q[i]  <= '0;
      end
      state_q     <= IDLE;
      irq_q       <= '0;
      level_out_q <= '0;
      shv_out_q   <= 1'b0;
      priv_out_q  <= '0;
      sel_id_q    <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      prev_src_q <= irq_src_i;
      pend_q     <= pend_d;
      for (int i = 0; i < NumInterrupts; i++) begin
        if (cfg_sel[i]) begin
          ie_q[i]    <= cfg_ie_i;
          edge_q[i]  <= cfg_edge_i;
          level_q[i] <= cfg_level_i;
          shv_q[i]   <= cfg_shv_i;
          priv_q[i]  <= cfg_priv_i;
        end
      end
      state_q     <= state_d;
      irq_q       <= irq_d;
      level_out_q <= level_out_d;
      shv_out_q   <= shv_out_d;
      priv_out_q  <= priv_out_d;
      sel_id_q    <= sel_id_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign irq_o          = irq_q;
  assign irq_level_o    = level_out_q;
  assign irq_shv_o      = shv_out_q;
  assign irq_priv_o     = priv_out_q;
  assign ack_mismatch_o = mismatch_q;

endmodule

// File: tb/tb_ibex_clic_arbiter.sv
// Self-checking bench for ibex_clic_arbiter: per-cycle vectors carry inputs
// and the outputs expected after the following clock edge.
module tb_ibex_clic_arbiter;

  localparam int N  = 64;
  localparam int LW = 8;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_src;
  logic          cfg_we;
  logic [IW-1:0] cfg_id;
  logic          cfg_ie;
  logic          cfg_edge;
  logic [LW-1:0] cfg_level;
  logic          cfg_shv;
  logic [1:0]    cfg_priv;
  logic [LW-1:0] irq_thresh;
  logic [IW-1:0] core_irq_id;
  logic          core_irq_ack;
  logic [N-1:0]  irq;
  logic [LW-1:0] irq_level;
  logic          irq_shv;
  logic [1:0]    irq_priv;
  logic          ack_mismatch;

  ibex_clic_arbiter #(.NumInterrupts(N), .LevelW(LW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .irq_src_i      (irq_src),
    .cfg_we_i       (cfg_we),
    .cfg_id_i       (cfg_id),
    .cfg_ie_i       (cfg_ie),
    .cfg_edge_i     (cfg_edge),
    .cfg_level_i    (cfg_level),
    .cfg_shv_i      (cfg_shv),
    .cfg_priv_i     (cfg_priv),
    .irq_thresh_i   (irq_thresh),
    .core_irq_id_i  (core_irq_id),
    .core_irq_ack_i (core_irq_ack),
    .irq_o          (irq),
    .irq_level_o    (irq_level),
    .irq_shv_o      (irq_shv),
    .irq_priv_o     (irq_priv),
    .ack_mismatch_o (ack_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [N-1:0]  src;
    logic          ack;
    logic [IW-1:0] ack_id;
    logic [LW-1:0] thresh;
    logic          exp_valid;
    logic [IW-1:0] exp_id;
    logic          exp_mm;
  } vec_t;

  typedef struct {
    int            step;
    logic          valid;
    logic [IW-1:0] id;
    logic          mm;
  } exp_t;

  exp_t          exp_q[$];
  vec_t          tbl[$];
  logic [LW-1:0] mdl_level [N];
  logic          mdl_shv   [N];
  logic [1:0]    mdl_priv  [N];
  int            tests = 0;
  int            fails = 0;
  int            step_no = 0;
  string         phase = "reset";

  function automatic vec_t mk(input logic r, input logic [N-1:0] s, input logic a,
                              input int aid, input int th, input logic ev,
                              input int eid, input logic emm);
    vec_t v;
    v.rst       = r;
    v.src       = s;
    v.ack       = a;
    v.ack_id    = IW'(aid);
    v.thresh    = LW'(th);
    v.exp_valid = ev;
    v.exp_id    = IW'(eid);
    v.exp_mm    = emm;
    return v;
  endfunction

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic cfgWrite(input int id, input logic ie, input logic edg, input int lvl,
                          input logic shv, input logic [1:0] priv);
    @(negedge clk);
    rst          = 1'b0;
    irq_src      = '0;
    core_irq_ack = 1'b0;
    cfg_we       = 1'b1;
    cfg_id       = IW'(id);
    cfg_ie       = ie;
    cfg_edge     = edg;
    cfg_level    = LW'(lvl);
    cfg_shv      = shv;
    cfg_priv     = priv;
    mdl_level[id] = LW'(lvl);
    mdl_shv[id]   = shv;
    mdl_priv[id]  = priv;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst          = v.rst;
    irq_src      = v.src;
    core_irq_ack = v.ack;
    core_irq_id  = v.ack_id;
    irq_thresh   = v.thresh;
    step_no++;
    e.step  = step_no;
    e.valid = v.exp_valid;
    e.id    = v.exp_id;
    e.mm    = v.exp_mm;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t          e;
    logic [N-1:0]  ei;
    logic [LW-1:0] el;
    logic          es;
    logic [1:0]    ep;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: scoreboard empty when output sampled", phase);
      return;
    end
    e  = exp_q.pop_front();
    ei = e.valid ? bit_of(int'(e.id)) : '0;
    el = e.valid ? mdl_level[e.id] : '0;
    es = e.valid ? mdl_shv[e.id] : 1'b0;
    ep = e.valid ? mdl_priv[e.id] : 2'b0;
    if (irq !== ei || irq_level !== el || irq_shv !== es || irq_priv !== ep ||
        ack_mismatch !== e.mm) begin
      fails++;
      $display("[TB] FAIL %s step%0d: got irq=%h lvl=%h shv=%b priv=%0d mm=%b, want irq=%h lvl=%h shv=%b priv=%0d mm=%b",
               phase, e.step, irq, irq_level, irq_shv, irq_priv, ack_mismatch,
               ei, el, es, ep, e.mm);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Safety net in case the bench ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      mdl_level[i] = '0;
      mdl_shv[i]   = 1'b0;
      mdl_priv[i]  = '0;
    end
    rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_id = '0; cfg_ie = 1'b0;
    cfg_edge = 1'b0; cfg_level = '0; cfg_shv = 1'b0; cfg_priv = '0;
    irq_thresh = '0; core_irq_id = '0; core_irq_ack = 1'b0;

    phase = "reset";
    runVec(mk(1, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(1, '0, 0, 0, 0, 0, 0, 0));

    cfgWrite(5,  1, 1, 8'h40, 1, 2'd3);
    cfgWrite(3,  1, 1, 8'h80, 0, 2'd1);
    cfgWrite(9,  1, 1, 8'h80, 1, 2'd2);
    cfgWrite(12, 1, 1, 8'h20, 0, 2'd0);
    cfgWrite(7,  1, 1, 8'h10, 0, 2'd1);
    cfgWrite(2,  1, 1, 8'h90, 1, 2'd3);
    cfgWrite(20, 1, 0, 8'h30, 0, 2'd1);
    cfgWrite(4,  1, 1, 8'h50, 1, 2'd0);
    cfgWrite(6,  1, 1, 8'h05, 0, 2'd2);

    // single edge source
    tbl.push_back(mk(0, bit_of(5), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 5, 0));
    tbl.push_back(mk(0, '0, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 0, 0, 0));
    // priority and tie-break
    tbl.push_back(mk(0, bit_of(3) | bit_of(9) | bit_of(12), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 9, 0));
    tbl.push_back(mk(0, '0, 1, 9, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(0, '0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 12, 0));
    tbl.push_back(mk(0, '0, 1, 12, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 0, 0, 0));
    // threshold and preemption
    tbl.push_back(mk(0, bit_of(7), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 7, 0));
    tbl.push_back(mk(0, '0, 0, 0, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 7, 0));
    tbl.push_back(mk(0, bit_of(2), 0, 0, 0, 1, 7, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(0, '0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 1, 7, 0));
    tbl.push_back(mk(0, '0, 1, 7, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 0, 0, 0));

    phase = "table";
    for (int i = 0; i < tbl.size(); i++) runVec(tbl[i]);

    // level-triggered source re-presents after the blank cycle while held
    phase = "level";
    runVec(mk(0, bit_of(20), 0, 0, 0, 1, 20, 0));
    runVec(mk(0, bit_of(20), 1, 20, 0, 0, 0, 0));
    runVec(mk(0, bit_of(20), 0, 0, 0, 1, 20, 0));
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));

    // same-cycle set and ack, mismatched ack, ack while idle
    phase = "corner";
    runVec(mk(0, bit_of(4), 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 1, 4, 0));
    runVec(mk(0, bit_of(4), 1, 4, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 1, 4, 0));
    runVec(mk(0, bit_of(6), 0, 0, 0, 1, 4, 0));
    runVec(mk(0, '0, 0, 0, 0, 1, 4, 0));
    runVec(mk(0, '0, 1, 6, 0, 0, 0, 1));
    runVec(mk(0, '0, 0, 0, 0, 1, 4, 0));
    runVec(mk(0, '0, 1, 4, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 1, 4, 0, 0, 0, 1));
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));

    // reset while presenting drops the interrupt and clears all state
    phase = "midreset";
    runVec(mk(0, bit_of(5), 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 1, 5, 0));
    runVec(mk(1, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(1, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));
    cfgWrite(5, 1, 1, 8'h40, 1, 2'd3);
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 0, 0, 0));
    runVec(mk(0, bit_of(5), 0, 0, 0, 0, 0, 0));
    runVec(mk(0, '0, 0, 0, 0, 1, 5, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
